dff_frame_rx: RTL and testbench
===============================

Name: dff_frame_rx

Overview:
- Downstream consumer of the registered serial bit stream produced by the single-bit D flip-flop stage.
- Watches the flopped bit stream for a start bit, shifts in a fixed-width data word LSB-first, then checks an even-parity bit.
- Presents each completed word with a one-cycle valid strobe and a parity-error flag.
- Keeps a saturating count of parity errors for the testbench scoreboard and coverage.

Parameters:
- WIDTH, 8, number of data bits per frame (legal range 2..32).
- ERR_CNT_W, 8, width of the saturating parity-error counter.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  1  serial bit from the upstream D-FF output.
- din_valid  input  1  qualifies din; din is sampled only on edges where din_valid=1.
- dout  output  WIDTH  last received data word, LSB = first data bit received.
- dout_valid  output  1  one-cycle pulse; dout and parity_err are valid in this cycle.
- parity_err  output  1  set if the frame just delivered failed the even-parity check.
- busy  output  1  high while a frame is in progress (state is not IDLE).
- err_cnt  output  ERR_CNT_W  number of parity errors since reset; saturates at all-ones.

Behaviour:
- Reset: rst is sampled on the rising edge of clk only (synchronous, active-high). On a reset edge:
  - state goes to IDLE; the shift register and bit counter clear to 0.
  - dout=0, dout_valid=0, parity_err=0, busy=0, err_cnt=0.
- Reset wins over every other event on the same edge.
- State machine: IDLE -> DATA -> PARITY -> IDLE.
- IDLE:
  - din_valid=1 and din=1 is a start bit: go to DATA and clear the bit counter.
  - din_valid=1 and din=0 is idle line: stay in IDLE.
- DATA:
  - Each din_valid=1 edge shifts din into bit position bit_cnt and increments bit_cnt.
  - After WIDTH bits have been captured, go to PARITY.
- PARITY, on a din_valid=1 edge:
  - Compute err = XOR of the WIDTH data bits XOR din. err=1 means the frame fails even parity.
  - Register the captured word into dout and err into parity_err, and set dout_valid=1 for exactly the next cycle.
  - If err=1 and err_cnt is not all-ones, increment err_cnt.
  - Go to IDLE.
- Stalls: on any edge with din_valid=0, state, counter and shift register hold. Stalls of any length are allowed in any state.
- Latency: dout_valid rises on the clock edge that samples the parity bit, i.e. it is high during the cycle after the parity bit was presented on din.
- dout_valid is high for exactly one cycle per frame. dout and parity_err hold their values until the next frame completes or reset.
- busy=1 in DATA and PARITY, busy=0 in IDLE.
- Back-to-back frames: a start bit presented in the cycle immediately after the parity bit is accepted, with no dead cycle. That cycle is also the cycle in which dout_valid=1 for the previous frame.
- A bit equal to 1 seen in DATA or PARITY is always treated as data or parity, never as a start bit.
- Reset mid-frame: the partial frame is discarded, no dout_valid is produced, and err_cnt clears.
- X on din while din_valid=0 must not corrupt any state.

Test Plan:
- Good frame, WIDTH=8:
  - Stimulus: start bit 1; data bits 1,0,1,0,0,1,0,1 (0xA5 LSB-first); parity bit 0; din_valid=1 throughout.
  - Response: dout=0xA5, parity_err=0, one dout_valid pulse, err_cnt=0; busy=1 for 9 cycles.
- Bad parity:
  - Stimulus: same frame with parity bit 1.
  - Response: dout=0xA5, parity_err=1, err_cnt=1.
- Stalls:
  - Stimulus: 0x3C frame (parity 0) with din_valid=0 for 3 cycles after the start bit and 2 cycles before the parity bit; din=X during the stalls.
  - Response: dout=0x3C, parity_err=0, one pulse, arriving 5 cycles later than the unstalled case.
- Back-to-back frames:
  - Stimulus: 0x3C (parity 0) followed immediately by 0xFF (parity 0).
  - Response: two dout_valid pulses 10 cycles apart, values 0x3C then 0xFF, no parity errors.
- Reset mid-frame:
  - Stimulus: rst=1 for one cycle after 4 data bits, then a complete 0x81 frame (parity 0).
  - Response: no pulse for the aborted frame; dout=0x81, parity_err=0, err_cnt=0.
- Saturation:
  - Stimulus: ERR_CNT_W=2; send 5 bad-parity frames.
  - Response: err_cnt reads 1, 2, 3, 3, 3; parity_err=1 on each frame.

Source files
------------

// File: rtl/dff_frame_rx_if.sv
// -----------------------------------------------------------------------------
// dff_frame_rx_if
// Bundles the serial input and the word-level outputs of dff_frame_rx.
//   master : drives din/din_valid, observes the received-word outputs
//   slave  : the receiver itself (consumes din, produces dout & status)
// Signals:
//   din        serial bit from the upstream D-FF
//   din_valid  qualifies din
//   dout       last received word, LSB = first data bit
//   dout_valid one-cycle strobe for dout/parity_err
//   parity_err last delivered frame failed even parity
//   busy       frame in progress
//   err_cnt    saturating parity-error count
// -----------------------------------------------------------------------------
interface dff_frame_rx_if #(
  parameter int WIDTH     = 8,
  parameter int ERR_CNT_W = 8
);
  logic                 din;
  logic                 din_valid;
  logic [WIDTH-1:0]     dout;
  logic                 dout_valid;
  logic                 parity_err;
  logic                 busy;
  logic [ERR_CNT_W-1:0] err_cnt;

  modport master (
    output din, din_valid,
    input  dout, dout_valid, parity_err, busy, err_cnt
  );

  modport slave (
    input  din, din_valid,
    output dout, dout_valid, parity_err, busy, err_cnt
  );
endinterface

// File: rtl/dff_frame_rx.sv
// -----------------------------------------------------------------------------
// dff_frame_rx
// Serial frame receiver: start bit (1), WIDTH data bits LSB-first, one even
// parity bit. Every completed frame is presented with a one-cycle strobe and a
// parity-error flag; parity errors are counted in a saturating counter.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  dff_frame_rx_if.slave (din, din_valid in; dout, dout_valid,
//        parity_err, busy, err_cnt out)
// -----------------------------------------------------------------------------
module dff_frame_rx #(
  parameter int WIDTH     = 8,
  parameter int ERR_CNT_W = 8
) (
  input logic           clk,
  input logic           rst,
  dff_frame_rx_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDTH-1:0]     r_shift;
  logic [CNT_W-1:0]     r_bit_cnt;
  logic [WIDTH-1:0]     r_dout;
  logic                 r_dout_valid;
  logic                 r_parity_err;
  logic [ERR_CNT_W-1:0] r_err_cnt;
  logic                 w_frame_done;
  logic                 w_err;

  // Next-state and frame-completion decode. din is only looked at when
  // din_valid is high, so an unknown din during a stall never propagates.
  always_comb begin
    w_state_nxt  = r_state;
    w_frame_done = 1'b0;
    w_err        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.din_valid && bus.din) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        if (bus.din_valid && (r_bit_cnt == LAST_BIT)) w_state_nxt = S_PARITY;
      end
      S_PARITY: begin
        if (bus.din_valid) begin
          w_state_nxt  = S_IDLE;
          w_frame_done = 1'b1;
          w_err        = (^r_shift) ^ bus.din;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, shifter and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_parity_err <= 1'b0;
      r_err_cnt    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_dout_valid <= w_frame_done;
      if (bus.din_valid) begin
        case (r_state)
          S_IDLE: begin
            r_bit_cnt <= '0;
          end
          S_DATA: begin
            // Shifting in from the MSB end leaves the first bit at the LSB
            // once WIDTH bits have arrived.
            r_shift   <= {bus.din, r_shift[WIDTH-1:1]};
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
          end
          S_PARITY: begin
            r_dout       <= r_shift;
            r_parity_err <= w_err;
            if (w_err && !(&r_err_cnt)) r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_dout_valid;
  assign bus.parity_err = r_parity_err;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_dff_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_dff_frame_rx
// Drives two receivers (8-bit and 2-bit error counters) with the same serial
// stream and checks them against frame-level expectations.
// -----------------------------------------------------------------------------
module tb_dff_frame_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;
  logic din_valid = 1'b0;

  always #5 clk = ~clk;

  dff_frame_rx_if #(.WIDTH(8), .ERR_CNT_W(8)) bus8 ();
  dff_frame_rx_if #(.WIDTH(8), .ERR_CNT_W(2)) bus2 ();

  assign bus8.din       = din;
  assign bus8.din_valid = din_valid;
  assign bus2.din       = din;
  assign bus2.din_valid = din_valid;

  dff_frame_rx #(.WIDTH(8), .ERR_CNT_W(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));
  dff_frame_rx #(.WIDTH(8), .ERR_CNT_W(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Reference state: expected outputs after the most recent frame
  int         exp_cnt8  = 0;
  int         exp_cnt2  = 0;
  logic [7:0] exp_dout  = 8'h00;
  logic       exp_perr  = 1'b0;
  int         last_pulse = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, wait for the edge, settle 1 time unit.
  task automatic tick(input logic v, input logic b);
    din_valid = v;
    din       = v ? b : 1'bx;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_dv"},   32'(bus8.dout_valid), 32'd0);
    chk({tag, "_busy"}, 32'(bus8.busy),       32'd0);
    chk({tag, "_dout"}, 32'(bus8.dout),       32'(exp_dout));
    chk({tag, "_perr"}, 32'(bus8.parity_err), 32'(exp_perr));
  endtask

  // Sends a full frame with optional stalls after the start bit and before the
  // parity bit, then checks the delivered word, flag, counters and latency.
  task automatic send_frame(input logic [7:0] w, input logic p,
                            input int st_a, input int st_b, input string tag);
    int   t0;
    logic perr;
    tick(1'b1, 1'b1);
    t0 = cyc;
    chk({tag, "_start_busy"}, 32'(bus8.busy), 32'd1);
    chk({tag, "_start_dv"},   32'(bus8.dout_valid), 32'd0);
    for (int s = 0; s < st_a; s++) begin
      tick(1'b0, 1'b0);
      chk({tag, "_stallA_busy"}, 32'(bus8.busy), 32'd1);
    end
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, w[i]);
      chk({tag, "_data_dv"},   32'(bus8.dout_valid), 32'd0);
      chk({tag, "_data_busy"}, 32'(bus8.busy),       32'd1);
    end
    for (int s = 0; s < st_b; s++) begin
      tick(1'b0, 1'b0);
      chk({tag, "_stallB_dv"}, 32'(bus8.dout_valid), 32'd0);
    end
    tick(1'b1, p);
    perr = (^w) ^ p;
    if (perr) begin
      if (exp_cnt8 < 255) exp_cnt8++;
      if (exp_cnt2 < 3)   exp_cnt2++;
    end
    exp_dout = w;
    exp_perr = perr;
    chk({tag, "_dv"},      32'(bus8.dout_valid), 32'd1);
    chk({tag, "_dout"},    32'(bus8.dout),       32'(exp_dout));
    chk({tag, "_perr"},    32'(bus8.parity_err), 32'(exp_perr));
    chk({tag, "_cnt8"},    32'(bus8.err_cnt),    32'(exp_cnt8));
    chk({tag, "_cnt2"},    32'(bus2.err_cnt),    32'(exp_cnt2));
    chk({tag, "_dv2"},     32'(bus2.dout_valid), 32'd1);
    chk({tag, "_busy"},    32'(bus8.busy),       32'd0);
    chk({tag, "_latency"}, 32'(cyc - t0),        32'(9 + st_a + st_b));
    last_pulse = cyc;
  endtask

  initial begin
    int p1;
    logic [7:0] w;
    logic       pb;

    // Reset state
    rst = 1'b1;
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    chk("rst_dout", 32'(bus8.dout),       32'd0);
    chk("rst_dv",   32'(bus8.dout_valid), 32'd0);
    chk("rst_perr", 32'(bus8.parity_err), 32'd0);
    chk("rst_busy", 32'(bus8.busy),       32'd0);
    chk("rst_cnt",  32'(bus8.err_cnt),    32'd0);
    rst = 1'b0;
    tick(1'b1, 1'b0);
    chk_idle("idle0");

    // Good frame then bad parity
    send_frame(8'hA5, 1'b0, 0, 0, "good");
    tick(1'b1, 1'b0);
    chk_idle("good_after");
    send_frame(8'hA5, 1'b1, 0, 0, "badpar");
    tick(1'b0, 1'b0);
    chk_idle("bad_after");

    // Stalls with X on din
    send_frame(8'h3C, 1'b0, 3, 2, "stall");
    tick(1'b1, 1'b0);
    chk_idle("stall_after");

    // Back-to-back frames
    send_frame(8'h3C, 1'b0, 0, 0, "b2b_a");
    p1 = last_pulse;
    send_frame(8'hFF, 1'b0, 0, 0, "b2b_b");
    chk("b2b_spacing", 32'(last_pulse - p1), 32'd10);
    tick(1'b1, 1'b0);
    chk_idle("b2b_after");

    // Reset mid-frame
    tick(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1);
    rst = 1'b1;
    tick(1'b1, 1'b1);
    rst = 1'b0;
    exp_cnt8 = 0; exp_cnt2 = 0; exp_dout = 8'h00; exp_perr = 1'b0;
    chk_idle("midrst");
    chk("midrst_cnt", 32'(bus8.err_cnt), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, 1'b0);
      chk("midrst_nopulse", 32'(bus8.dout_valid), 32'd0);
    end
    send_frame(8'h81, 1'b0, 0, 0, "post_rst");

    // Saturation of the 2-bit counter
    for (int k = 0; k < 5; k++) begin
      tick(1'b1, 1'b0);
      send_frame(8'h5A, 1'b1, 0, 0, "sat");
    end
    chk("sat_final2", 32'(bus2.err_cnt), 32'd3);

    // Randomized frames with random stalls and idle gaps
    for (int k = 0; k < 40; k++) begin
      w  = 8'($urandom_range(0, 255));
      pb = 1'($urandom_range(0, 1));
      send_frame(w, pb, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), "rnd");
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        if ($urandom_range(0, 1) == 1) tick(1'b1, 1'b0);
        else tick(1'b0, 1'b0);
        chk_idle("rnd_gap");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
